// File: rtl/sd_spi_master_if.sv
// Bus-side handshake between the register shim and sd_spi_master.
// The shim uses the master modport; the SPI engine uses the slave modport.
// crc_clr_i / crc7_o are only functional when SD_SPI_CRC7_EN is defined.
interface sd_spi_master_if #(
   parameter int DATA_W   = 8,
   parameter int CS_COUNT = 2,
   parameter int DIV_W    = 8
);
   localparam int SEL_W = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;

   logic              start_i;
   logic [DATA_W-1:0] tx_data_i;
   logic [DIV_W-1:0]  div_i;
   logic              cpol_i;
   logic              cpha_i;
   logic [SEL_W-1:0]  cs_sel_i;
   logic              cs_hold_i;
   logic              crc_clr_i;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] rx_data_o;
   logic [6:0]        crc7_o;

   modport master (
      output start_i, tx_data_i, div_i, cpol_i, cpha_i, cs_sel_i, cs_hold_i, crc_clr_i,
      input  busy_o, done_o, rx_data_o, crc7_o
   );

   modport slave (
      input  start_i, tx_data_i, div_i, cpol_i, cpha_i, cs_sel_i, cs_hold_i, crc_clr_i,
      output busy_o, done_o, rx_data_o, crc7_o
   );
endinterface

// File: rtl/sd_spi_master.sv
// SPI master for SD cards and general SPI peripherals: programmable SCK
// half-period divider, CPOL/CPHA, MSB-first words of DATA_W bits, CS_COUNT
// active-low chip selects and CS hold across multi-word frames.
// Optional CRC7 of outgoing MOSI bits is enabled by defining SD_SPI_CRC7_EN.
module sd_spi_master #(
   parameter int DATA_W   = 8,
   parameter int CS_COUNT = 2,
   parameter int DIV_W    = 8
) (
   input  logic                CLOCK,
   input  logic                RESET,
   sd_spi_master_if.slave      bus,
   output logic                SPI_SCK,
   output logic                SPI_MOSI,
   input  logic                SPI_MISO,
   output logic [CS_COUNT-1:0] SPI_CS_N
);

   localparam int SEL_W = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;
   localparam int HP_W  = $clog2(2 * DATA_W + 1);

   // Last XFER half-period, and the one ending in the final trailing edge.
   localparam logic [HP_W-1:0] HP_LAST       = HP_W'(2 * DATA_W - 1);
   localparam logic [HP_W-1:0] HP_LAST_TRAIL = HP_W'(2 * DATA_W - 2);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, TRAIL, HOLD} state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    cnt_q;
   logic [DIV_W-1:0]    div_q;
   logic [HP_W-1:0]     hp_q;
   logic                cpol_q, cpha_q, hold_q;
   logic [DATA_W-1:0]   tx_sh_q, rx_sh_q, rx_data_q;
   logic                sck_q, mosi_q, busy_q, done_q;
   logic [CS_COUNT-1:0] cs_n_q;

   logic accept, half_end, edge_now, edge_lead, xfer_end, trail_end, hold_exit;
   logic drive_en, drive_bit, sample_en;

   // Out-of-range selects leave every chip select deasserted.
   function automatic logic [CS_COUNT-1:0] cs_decode(input logic [SEL_W-1:0] sel);
      logic [CS_COUNT-1:0] v;
      v = '1;
      for (int i = 0; i < CS_COUNT; i++)
         if (sel == SEL_W'(i)) v[i] = 1'b0;
      return v;
   endfunction

   // State register.
   always_ff @(posedge CLOCK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode plus per-cycle strobes for the datapath.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d   = state_q;
      accept    = 1'b0;
      half_end  = (cnt_q == div_q);
      edge_now  = 1'b0;
      edge_lead = (state_q == SETUP) || hp_q[0];
      xfer_end  = 1'b0;
      trail_end = 1'b0;
      hold_exit = 1'b0;
      drive_en  = 1'b0;
      drive_bit = tx_sh_q[DATA_W-1];
      sample_en = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               accept  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (half_end) begin
               edge_now = 1'b1;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (half_end) begin
               if (hp_q == HP_LAST) begin
                  xfer_end = 1'b1;
                  state_d  = hold_q ? HOLD : TRAIL;
               end else begin
                  edge_now = 1'b1;
               end
            end
         end
         TRAIL: begin
            if (half_end) begin
               trail_end = 1'b1;
               state_d   = IDLE;
            end
         end
         HOLD: begin
            if (bus.start_i) begin
               accept  = 1'b1;
               state_d = SETUP;
            end else if (!bus.cs_hold_i) begin
               hold_exit = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A MOSI bit is driven at accept (CPHA=0 first bit), on trailing edges
      // for CPHA=0 (except after the last bit) and on leading edges for CPHA=1.
      if (accept) begin
         drive_en  = !bus.cpha_i;
         drive_bit = bus.tx_data_i[DATA_W-1];
      end else if (edge_now) begin
         drive_en = cpha_q ? edge_lead : (!edge_lead && (hp_q != HP_LAST_TRAIL));
      end
      sample_en = edge_now && (edge_lead ^ cpha_q);
   end

   // Datapath: divider, shift registers, SPI pins and handshake outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cnt_q     <= '0;
         div_q     <= '0;
         hp_q      <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         hold_q    <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= '1;
      end else begin
         done_q <= 1'b0;
         if (state_q == SETUP || state_q == XFER || state_q == TRAIL)
            cnt_q <= half_end ? '0 : cnt_q + 1'b1;

         if (accept) begin
            div_q   <= bus.div_i;
            cpol_q  <= bus.cpol_i;
            cpha_q  <= bus.cpha_i;
            hold_q  <= bus.cs_hold_i;
            tx_sh_q <= drive_en ? (bus.tx_data_i << 1) : bus.tx_data_i;
            mosi_q  <= drive_en ? drive_bit : 1'b1;
            cnt_q   <= '0;
            hp_q    <= '0;
            busy_q  <= 1'b1;
            cs_n_q  <= cs_decode(bus.cs_sel_i);
            sck_q   <= bus.cpol_i;
         end else begin
            if (state_q == IDLE) begin
               sck_q  <= bus.cpol_i;
               mosi_q <= 1'b1;
            end
            if (state_q == HOLD) sck_q <= cpol_q;
            if (edge_now) sck_q <= ~sck_q;
            if (edge_now && state_q == XFER) hp_q <= hp_q + 1'b1;
            if (drive_en) begin
               mosi_q  <= drive_bit;
               tx_sh_q <= tx_sh_q << 1;
            end
            if (sample_en) rx_sh_q <= {rx_sh_q[DATA_W-2:0], SPI_MISO};
            if ((xfer_end && hold_q) || trail_end) begin
               done_q    <= 1'b1;
               rx_data_q <= rx_sh_q;
               busy_q    <= 1'b0;
            end
            if (trail_end || hold_exit) cs_n_q <= '1;
         end
      end
   end

`ifdef SD_SPI_CRC7_EN
   logic [6:0] crc_q;

   // CRC7 step for polynomial x^7 + x^3 + 1, one bit per call.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // CRC7 accumulator over every bit placed on MOSI; clear wins over update.
   always_ff @(posedge CLOCK) begin
      if (RESET || bus.crc_clr_i) crc_q <= '0;
      else if (drive_en)          crc_q <= crc7_step(crc_q, drive_bit);
   end

   assign bus.crc7_o = crc_q;
`else
   assign bus.crc7_o = '0;
`endif

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.rx_data_o = rx_data_q;
   assign SPI_SCK       = sck_q;
   assign SPI_MOSI      = mosi_q;
   assign SPI_CS_N      = cs_n_q;

endmodule
